// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// master = controller, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               overflow;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic               EPCWrite;
  logic               CauseWrite;
  logic [2:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic [1:0]         cause;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  opcode, funct, overflow, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead,
    output MemWrite, IRWrite, MemtoReg, RegDst,
    output RegWrite, ALUSrcA, EPCWrite, CauseWrite,
    output ALUSrcB, ALUOp, PCSource, cause, state_o
  );

  modport slave (
    output opcode, funct, overflow, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead,
    input  MemWrite, IRWrite, MemtoReg, RegDst,
    input  RegWrite, ALUSrcA, EPCWrite, CauseWrite,
    input  ALUSrcB, ALUOp, PCSource, cause, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: fetch/decode/execute
// sequencing, memory-ready stalls with timeout, and exception entry.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input logic              clk,
  input logic              reset_n,
  multicycle_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, R_EXEC, R_WB,
    ADDI_EXEC, ADDI_WB, MEM_ADDR, MEM_READ,
    MEM_WRITE, MEM_WB, BRANCH, JUMP,
    JR, EXCEPT
  } state_t;

  state_t     state, nxt;
  logic [1:0] cause_q, nxt_cause;
  logic [CNT_W-1:0] cnt;

  logic wait_st;
  logic timeout;
  logic op_r, op_jr, op_ls, op_beq, op_j, op_addi;

  assign wait_st = (state == FETCH) ||
                   (state == MEM_READ) ||
                   (state == MEM_WRITE);
  // last tolerated stall cycle: the next one would reach MEM_TIMEOUT-1
  assign timeout = wait_st && !bus.mem_ready &&
                   (cnt == CNT_W'(MEM_TIMEOUT - 2));

  assign op_r    = bus.opcode == 6'h00;
  assign op_jr   = op_r && (bus.funct == 6'h08);
  assign op_ls   = (bus.opcode == 6'h23) ||
                   (bus.opcode == 6'h2B);
  assign op_beq  = bus.opcode == 6'h04;
  assign op_j    = bus.opcode == 6'h02;
  assign op_addi = bus.opcode == 6'h08;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      cause_q <= 2'b00;
      cnt     <= '0;
    end else begin
      state   <= nxt;
      cause_q <= nxt_cause;
      if (nxt != state)
        cnt <= '0;
      else if (wait_st && !bus.mem_ready)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt       = state;
    nxt_cause = cause_q;
    unique case (state)
      FETCH: begin
        if (bus.mem_ready) begin
          nxt = DECODE;
        end else if (timeout) begin
          nxt       = EXCEPT;
          nxt_cause = 2'b10;
        end
      end
      DECODE: begin
        unique case (1'b1)
          op_jr:          nxt = JR;
          op_r && !op_jr: nxt = R_EXEC;
          op_ls:          nxt = MEM_ADDR;
          op_beq:         nxt = BRANCH;
          op_j:           nxt = JUMP;
          op_addi:        nxt = ADDI_EXEC;
          default: begin
            nxt       = EXCEPT;
            nxt_cause = 2'b01;
          end
        endcase
      end
      R_EXEC, ADDI_EXEC: begin
        if (bus.overflow) begin
          nxt       = EXCEPT;
          nxt_cause = 2'b00;
        end else begin
          nxt = (state == R_EXEC) ? R_WB : ADDI_WB;
        end
      end
      MEM_ADDR:
        nxt = (bus.opcode == 6'h23) ? MEM_READ : MEM_WRITE;
      MEM_READ, MEM_WRITE: begin
        if (bus.mem_ready) begin
          nxt = (state == MEM_READ) ? MEM_WB : FETCH;
        end else if (timeout) begin
          nxt       = EXCEPT;
          nxt_cause = 2'b10;
        end
      end
      R_WB, ADDI_WB, MEM_WB,
      BRANCH, JUMP, JR, EXCEPT:
        nxt = FETCH;
      default:
        nxt = FETCH;
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.EPCWrite    = 1'b0;
    bus.CauseWrite  = 1'b0;
    bus.ALUSrcB     = 3'b000;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.cause       = 2'b00;
    bus.state_o     = state;
    unique case (state)
      FETCH: begin
        // held in reset: FETCH values, but nothing is latched
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 3'b001;
        bus.IRWrite = bus.mem_ready & reset_n;
        bus.PCWrite = bus.mem_ready & reset_n;
      end
      DECODE: bus.ALUSrcB = 3'b011;
      R_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      R_WB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      ADDI_EXEC, MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 3'b010;
      end
      ADDI_WB: bus.RegWrite = 1'b1;
      MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEM_WRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      MEM_WB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      JR: begin
        bus.ALUSrcA = 1'b1;
        bus.PCWrite = 1'b1;
      end
      EXCEPT: begin
        bus.EPCWrite   = 1'b1;
        bus.CauseWrite = 1'b1;
        bus.PCWrite    = 1'b1;
        bus.PCSource   = 2'b11;
        bus.cause      = cause_q;
      end
      default: ;
    endcase
  end

endmodule
